// File: rtl/uivtg_timing_pkg.sv
// -----------------------------------------------------------------------------
// uivtg_timing_pkg
// Shared definitions for the uivtg video timing generator:
//   - counter width of the H/V raster counters
//   - FSM state encoding (2 bits)
//   - 1280x720 and 1920x1080 timing constant sets for top-level instantiation
//   - a half-open window decode helper used by the axis counters
// -----------------------------------------------------------------------------
package uivtg_timing_pkg;

    localparam int CNT_W  = 12;         // H/V counters; totals must be <= 4096
    localparam int CNT_WX = CNT_W + 1;  // one spare bit so window ends may equal 4096

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STOP_PEND = 2'd2
    } vtg_state_e;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } vtg_timing_t;

    localparam vtg_timing_t TIMING_720P = '{
        h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
        v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20
    };

    localparam vtg_timing_t TIMING_1080P = '{
        h_active: 1920, h_fp: 88, h_sync: 44, h_bp: 148,
        v_active: 1080, v_fp: 4,  v_sync: 5,  v_bp: 36
    };

    // True when lo <= cnt < hi. Bounds carry an extra bit so a window that
    // ends exactly at the counter's full range (4096) still decodes.
    function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W:0]   lo,
                                       input logic [CNT_W:0]   hi);
        return ({1'b0, cnt} >= lo) && ({1'b0, cnt} < hi);
    endfunction

endpackage

// File: rtl/uivtg_timing_if.sv
// -----------------------------------------------------------------------------
// uivtg_timing_if
// Raster bus between the timing generator and its consumers.
//   I_vtg_en    run request toward the generator
//   O_vtg_vs    vertical sync (level per VS_POL)
//   O_vtg_hs    horizontal sync (level per HS_POL)
//   O_vtg_de    active-video enable
//   O_vtg_x     pixel column while de=1, else 0
//   O_vtg_y     active line index while de=1, else 0
//   O_vtg_sof   pulse with first active pixel of a frame
//   O_vtg_eol   pulse with last active pixel of each active line
//   O_vtg_busy  generator not idle
// Modports: master = the generator, slave = a raster consumer / controller.
// -----------------------------------------------------------------------------
interface uivtg_timing_if;
    import uivtg_timing_pkg::*;

    logic             I_vtg_en;
    logic             O_vtg_vs;
    logic             O_vtg_hs;
    logic             O_vtg_de;
    logic [CNT_W-1:0] O_vtg_x;
    logic [CNT_W-1:0] O_vtg_y;
    logic             O_vtg_sof;
    logic             O_vtg_eol;
    logic             O_vtg_busy;

    modport master (
        input  I_vtg_en,
        output O_vtg_vs, O_vtg_hs, O_vtg_de, O_vtg_x, O_vtg_y,
               O_vtg_sof, O_vtg_eol, O_vtg_busy
    );

    modport slave (
        output I_vtg_en,
        input  O_vtg_vs, O_vtg_hs, O_vtg_de, O_vtg_x, O_vtg_y,
               O_vtg_sof, O_vtg_eol, O_vtg_busy
    );

endinterface

// File: rtl/uivtg_timing_axis_cnt.sv
// -----------------------------------------------------------------------------
// uivtg_axis_cnt
// One raster axis: a wrap counter 0..TOTAL-1 plus combinational window decode
// of the current count. Used once for H (advancing every clock) and once for
// V (advancing on the H wrap).
// Ports:
//   clk_i     pixel clock
//   rst_i     asynchronous reset, active-high (count -> 0)
//   clr_i     synchronous clear to 0 (has priority over inc_i)
//   inc_i     advance one step; wraps TOTAL-1 -> 0
//   cnt_o     current count
//   last_o    count == TOTAL-1
//   active_o  count in [0, ACTIVE)
//   sync_o    count in [SYNC_START, SYNC_START+SYNC_LEN)
// -----------------------------------------------------------------------------
module uivtg_axis_cnt
    import uivtg_timing_pkg::*;
#(
    parameter int TOTAL      = 16,
    parameter int ACTIVE     = 8,
    parameter int SYNC_START = 10,
    parameter int SYNC_LEN   = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o,
    output logic             active_o,
    output logic             sync_o
);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W:0]   ACT_HI  = CNT_WX'(ACTIVE);
    localparam logic [CNT_W:0]   SYNC_LO = CNT_WX'(SYNC_START);
    localparam logic [CNT_W:0]   SYNC_HI = CNT_WX'(SYNC_START + SYNC_LEN);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last_o = (cnt_q == LAST);

    always_comb begin
        // NOTE: default first so every path assigns cnt_d -- no latch.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop
    // samples the pre-edge value of its inputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign active_o = in_window(cnt_q, '0, ACT_HI);
    assign sync_o   = in_window(cnt_q, SYNC_LO, SYNC_HI);

endmodule

// File: rtl/uivtg_timing.sv
// -----------------------------------------------------------------------------
// uivtg_timing
// Video timing generator: free-running H/V counters with programmable porches,
// sync widths and polarities, producing the vs/hs/de raster plus pixel
// coordinates and sof/eol markers. Starting and stopping happen only at frame
// boundaries, so only complete frames are ever emitted.
// H_TOTAL and V_TOTAL must both be <= 4096.
// Ports:
//   I_vtg_clk   pixel clock
//   I_vtg_rst   asynchronous reset, active-high
//   vtg         uivtg_timing_if.master: I_vtg_en in; vs/hs/de/x/y/sof/eol/busy out
// All outputs are registered decodes of the counter/FSM state: latency 1.
// -----------------------------------------------------------------------------
module uivtg_timing
    import uivtg_timing_pkg::*;
#(
    parameter int H_ACTIVE = TIMING_720P.h_active,
    parameter int H_FP     = TIMING_720P.h_fp,
    parameter int H_SYNC   = TIMING_720P.h_sync,
    parameter int H_BP     = TIMING_720P.h_bp,
    parameter int V_ACTIVE = TIMING_720P.v_active,
    parameter int V_FP     = TIMING_720P.v_fp,
    parameter int V_SYNC   = TIMING_720P.v_sync,
    parameter int V_BP     = TIMING_720P.v_bp,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic           I_vtg_clk,
    input  logic           I_vtg_rst,
    uivtg_timing_if.master vtg
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST_ACT = CNT_W'(H_ACTIVE - 1);
    localparam logic             HS_ON      = HS_POL;
    localparam logic             HS_OFF     = ~HS_POL;
    localparam logic             VS_ON      = VS_POL;
    localparam logic             VS_OFF     = ~VS_POL;

    vtg_state_e       state_q;
    vtg_state_e       state_d;
    logic             idle;
    logic             frame_last;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_last,   v_last;
    logic             h_active, v_active;
    logic             h_sync,   v_sync;

    logic             vs_d,   vs_q;
    logic             hs_d,   hs_q;
    logic             de_d,   de_q;
    logic [CNT_W-1:0] x_d,    x_q;
    logic [CNT_W-1:0] y_d,    y_q;
    logic             sof_d,  sof_q;
    logic             eol_d,  eol_q;
    logic             busy_d, busy_q;

    assign idle       = (state_q == ST_IDLE);
    assign frame_last = h_last & v_last;

    // Counters sit at (0,0) while idle; the FSM only leaves RUN/STOP_PEND for
    // IDLE on the last pixel of a frame, where both counters wrap to 0 anyway.
    uivtg_axis_cnt #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_LEN   (H_SYNC)
    ) u_h_cnt (
        .clk_i    (I_vtg_clk),
        .rst_i    (I_vtg_rst),
        .clr_i    (idle),
        .inc_i    (~idle),
        .cnt_o    (h_cnt),
        .last_o   (h_last),
        .active_o (h_active),
        .sync_o   (h_sync)
    );

    uivtg_axis_cnt #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_LEN   (V_SYNC)
    ) u_v_cnt (
        .clk_i    (I_vtg_clk),
        .rst_i    (I_vtg_rst),
        .clr_i    (idle),
        .inc_i    (~idle & h_last),
        .cnt_o    (v_cnt),
        .last_o   (v_last),
        .active_o (v_active),
        .sync_o   (v_sync)
    );

    always_ff @(posedge I_vtg_clk or posedge I_vtg_rst) begin
        if (I_vtg_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A stop request is remembered in STOP_PEND and honoured at the end of the
    // frame in progress; re-raising en before then cancels it seamlessly.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (vtg.I_vtg_en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!vtg.I_vtg_en) state_d = ST_STOP_PEND;
            end
            ST_STOP_PEND: begin
                if (vtg.I_vtg_en)    state_d = ST_RUN;
                else if (frame_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Decode of the current (state, h, v); registered below.
    always_comb begin
        busy_d = ~idle;
        de_d   = busy_d & h_active & v_active;
        hs_d   = (busy_d & h_sync) ? HS_ON : HS_OFF;
        vs_d   = (busy_d & v_sync) ? VS_ON : VS_OFF;
        x_d    = de_d ? h_cnt : '0;
        y_d    = de_d ? v_cnt : '0;
        sof_d  = de_d & (h_cnt == '0) & (v_cnt == '0);
        eol_d  = de_d & (h_cnt == H_LAST_ACT);
    end

    always_ff @(posedge I_vtg_clk or posedge I_vtg_rst) begin
        if (I_vtg_rst) begin
            vs_q   <= VS_OFF;
            hs_q   <= HS_OFF;
            de_q   <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            sof_q  <= 1'b0;
            eol_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            vs_q   <= vs_d;
            hs_q   <= hs_d;
            de_q   <= de_d;
            x_q    <= x_d;
            y_q    <= y_d;
            sof_q  <= sof_d;
            eol_q  <= eol_d;
            busy_q <= busy_d;
        end
    end

    assign vtg.O_vtg_vs   = vs_q;
    assign vtg.O_vtg_hs   = hs_q;
    assign vtg.O_vtg_de   = de_q;
    assign vtg.O_vtg_x    = x_q;
    assign vtg.O_vtg_y    = y_q;
    assign vtg.O_vtg_sof  = sof_q;
    assign vtg.O_vtg_eol  = eol_q;
    assign vtg.O_vtg_busy = busy_q;

endmodule

// File: tb/tb_uivtg_timing.sv
// -----------------------------------------------------------------------------
// tb_uivtg_timing
// Small raster (H 8/2/3/3 -> 16 clocks/line, V 4/1/2/1 -> 8 lines, 128
// clocks/frame). Two generators share the stimulus: one with active-high
// syncs, one with active-low syncs. A frame-position model pushes the expected
// outputs for every clock to a queue; they are popped and compared one clock
// later against both generators. Each scenario task adds its own checks.
// -----------------------------------------------------------------------------
module tb_uivtg_timing;

    localparam int H_ACT  = 8;
    localparam int H_FP   = 2;
    localparam int H_SYNC = 3;
    localparam int H_BP   = 3;
    localparam int V_ACT  = 4;
    localparam int V_FP   = 1;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 1;
    localparam int HT     = 16;
    localparam int FRAME  = 128;

    typedef struct packed {
        logic        vs;
        logic        hs;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic        sof;
        logic        eol;
        logic        busy;
    } out_t;

    localparam out_t INACT_P = '{vs: 1'b0, hs: 1'b0, de: 1'b0, x: 12'd0, y: 12'd0,
                                 sof: 1'b0, eol: 1'b0, busy: 1'b0};
    localparam out_t INACT_N = '{vs: 1'b1, hs: 1'b1, de: 1'b0, x: 12'd0, y: 12'd0,
                                 sof: 1'b0, eol: 1'b0, busy: 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;

    uivtg_timing_if if_p ();
    uivtg_timing_if if_n ();

    uivtg_timing #(
        .H_ACTIVE (H_ACT), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACT), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HS_POL   (1'b1),  .VS_POL (1'b1)
    ) dut_p (
        .I_vtg_clk (clk),
        .I_vtg_rst (rst),
        .vtg       (if_p)
    );

    uivtg_timing #(
        .H_ACTIVE (H_ACT), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACT), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HS_POL   (1'b0),  .VS_POL (1'b0)
    ) dut_n (
        .I_vtg_clk (clk),
        .I_vtg_rst (rst),
        .vtg       (if_n)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Model: running flag, stop-pending flag, pixel position within the frame.
    bit   m_run  = 1'b0;
    bit   m_stop = 1'b0;
    int   m_p    = 0;
    out_t exp_q[$];

    function automatic out_t decode(input bit run, input int p);
        out_t o;
        int   h;
        int   v;
        h      = p % HT;
        v      = p / HT;
        o.de   = run && (h < H_ACT) && (v < V_ACT);
        o.hs   = run && (h >= H_ACT + H_FP) && (h < H_ACT + H_FP + H_SYNC);
        o.vs   = run && (v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SYNC);
        o.x    = o.de ? 12'(h) : 12'd0;
        o.y    = o.de ? 12'(v) : 12'd0;
        o.sof  = o.de && (p == 0);
        o.eol  = o.de && (h == H_ACT - 1);
        o.busy = run;
        return o;
    endfunction

    function automatic out_t sample_p();
        out_t o;
        o.vs = if_p.O_vtg_vs;  o.hs  = if_p.O_vtg_hs;  o.de  = if_p.O_vtg_de;
        o.x  = if_p.O_vtg_x;   o.y   = if_p.O_vtg_y;   o.sof = if_p.O_vtg_sof;
        o.eol = if_p.O_vtg_eol; o.busy = if_p.O_vtg_busy;
        return o;
    endfunction

    function automatic out_t sample_n();
        out_t o;
        o.vs = if_n.O_vtg_vs;  o.hs  = if_n.O_vtg_hs;  o.de  = if_n.O_vtg_de;
        o.x  = if_n.O_vtg_x;   o.y   = if_n.O_vtg_y;   o.sof = if_n.O_vtg_sof;
        o.eol = if_n.O_vtg_eol; o.busy = if_n.O_vtg_busy;
        return o;
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("vs=%b hs=%b de=%b x=%0d y=%0d sof=%b eol=%b busy=%b",
                         o.vs, o.hs, o.de, o.x, o.y, o.sof, o.eol, o.busy);
    endfunction

    task automatic model_reset();
        m_run  = 1'b0;
        m_stop = 1'b0;
        m_p    = 0;
        exp_q.delete();
    endtask

    // One clock: drive en, push the expectation for the state the DUT holds
    // now, advance the model, then pop and compare #1 after the edge.
    task automatic cycle(input bit en);
        out_t e;
        out_t a;
        bit   last;
        if_p.I_vtg_en = en;
        if_n.I_vtg_en = en;
        exp_q.push_back(decode(m_run, m_p));
        if (!m_run) begin
            if (en) begin
                m_run  = 1'b1;
                m_stop = 1'b0;
                m_p    = 0;
            end
        end else begin
            last = (m_p == FRAME - 1);
            if (en)                  m_stop = 1'b0;
            else if (m_stop && last) m_run  = 1'b0;
            else                     m_stop = 1'b1;
            m_p = last ? 0 : m_p + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
        e = exp_q.pop_front();
        a = sample_p();
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL sb_pos cyc=%0d: got %s, want %s", cyc, fmt(a), fmt(e));
        end
        e.vs = ~e.vs;
        e.hs = ~e.hs;
        a = sample_n();
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL sb_neg cyc=%0d: got %s, want %s", cyc, fmt(a), fmt(e));
        end
    endtask

    task automatic test_reset();
        out_t a;
        rst = 1'b1;
        if_p.I_vtg_en = 1'b1;
        if_n.I_vtg_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        a = sample_p();
        n_cmp++;
        if (a !== INACT_P) begin
            n_bad++;
            $display("FAIL reset_pos: got %s, want %s", fmt(a), fmt(INACT_P));
        end
        a = sample_n();
        n_cmp++;
        if (a !== INACT_N) begin
            n_bad++;
            $display("FAIL reset_neg: got %s, want %s", fmt(a), fmt(INACT_N));
        end
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_start();
        cycle(1'b1);
        n_cmp++;
        if (if_p.O_vtg_de !== 1'b0) begin
            n_bad++;
            $display("FAIL start_early_de: got %b, want 0", if_p.O_vtg_de);
        end
        cycle(1'b1);
        n_cmp++;
        if ({if_p.O_vtg_de, if_p.O_vtg_sof, if_p.O_vtg_x, if_p.O_vtg_y} !== {1'b1, 1'b1, 12'd0, 12'd0}) begin
            n_bad++;
            $display("FAIL start_first_pixel: got de=%b sof=%b x=%0d y=%0d, want de=1 sof=1 x=0 y=0",
                     if_p.O_vtg_de, if_p.O_vtg_sof, if_p.O_vtg_x, if_p.O_vtg_y);
        end
    endtask

    task automatic test_free_run();
        out_t o;
        bit   de_prev, hs_prev, vs_prev, armed;
        int   de_cnt = 0, eol_cnt = 0, sof_cnt = 0, hs_cnt = 0, vs_cnt = 0;
        int   de_rise = 0, last_sof;
        o        = sample_p();
        de_prev  = o.de;
        hs_prev  = o.hs;
        vs_prev  = o.vs;
        armed    = 1'b0;
        last_sof = o.sof ? cyc : -1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            cycle(1'b1);
            o = sample_p();
            if (o.de && !de_prev) begin
                de_rise = cyc;
                armed   = 1'b1;
            end
            if (o.hs && !hs_prev && armed) begin
                armed = 1'b0;
                n_cmp++;
                if (cyc - de_rise != 10) begin
                    n_bad++;
                    $display("FAIL hs_offset: got %0d clks after de rise, want 10", cyc - de_rise);
                end
            end
            if (o.vs && !vs_prev && last_sof >= 0) begin
                n_cmp++;
                if (cyc - last_sof != 5 * HT) begin
                    n_bad++;
                    $display("FAIL vs_offset: got %0d clks after sof, want %0d", cyc - last_sof, 5 * HT);
                end
            end
            if (o.sof) begin
                sof_cnt++;
                if (last_sof >= 0) begin
                    n_cmp++;
                    if (cyc - last_sof != FRAME) begin
                        n_bad++;
                        $display("FAIL sof_period: got %0d, want %0d", cyc - last_sof, FRAME);
                    end
                end
                last_sof = cyc;
            end
            if (o.eol) begin
                eol_cnt++;
                n_cmp++;
                if (o.x !== 12'd7) begin
                    n_bad++;
                    $display("FAIL eol_x: got %0d, want 7", o.x);
                end
            end
            de_cnt += int'(o.de);
            hs_cnt += int'(o.hs);
            vs_cnt += int'(o.vs);
            de_prev = o.de;
            hs_prev = o.hs;
            vs_prev = o.vs;
        end
        n_cmp++;
        if (de_cnt != 96) begin n_bad++; $display("FAIL free_de_count: got %0d, want 96", de_cnt); end
        n_cmp++;
        if (hs_cnt != 72) begin n_bad++; $display("FAIL free_hs_count: got %0d, want 72", hs_cnt); end
        n_cmp++;
        if (vs_cnt != 96) begin n_bad++; $display("FAIL free_vs_count: got %0d, want 96", vs_cnt); end
        n_cmp++;
        if (eol_cnt != 12) begin n_bad++; $display("FAIL free_eol_count: got %0d, want 12", eol_cnt); end
        n_cmp++;
        if (sof_cnt != 3) begin n_bad++; $display("FAIL free_sof_count: got %0d, want 3", sof_cnt); end
    endtask

    task automatic test_stop_mid();
        bit found = 1'b0;
        int fall = -1, eol_cnt = 0, de_idle = 0, busy_idle = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            cycle(1'b1);
            found = if_p.O_vtg_de && (if_p.O_vtg_y == 12'd2) && (if_p.O_vtg_x == 12'd0);
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL stop_wait_line2: got timeout, want line 2 start within 300 clks");
        end
        for (int i = 1; i <= 200; i++) begin
            cycle(1'b0);
            eol_cnt += int'(if_p.O_vtg_eol);
            if (!if_p.O_vtg_busy) begin
                fall = i;
                break;
            end
        end
        n_cmp++;
        if (fall != 96) begin n_bad++; $display("FAIL stop_busy_fall: got %0d, want 96", fall); end
        n_cmp++;
        if (eol_cnt != 2) begin n_bad++; $display("FAIL stop_eol_count: got %0d, want 2", eol_cnt); end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0);
            de_idle   += int'(if_p.O_vtg_de);
            busy_idle += int'(if_p.O_vtg_busy);
        end
        n_cmp++;
        if (de_idle != 0 || busy_idle != 0) begin
            n_bad++;
            $display("FAIL stop_idle: got de=%0d busy=%0d clks, want 0 and 0", de_idle, busy_idle);
        end
    endtask

    task automatic test_back_to_back();
        int  t0 = 0, wait_cnt = 0;
        bit  found = 1'b0;
        for (int i = 1; i <= 10 && !found; i++) begin
            cycle(1'b1);
            if (if_p.O_vtg_sof) begin
                found    = 1'b1;
                wait_cnt = i;
                t0       = cyc;
            end
        end
        n_cmp++;
        if (wait_cnt != 2) begin
            n_bad++;
            $display("FAIL restart_latency: got %0d clks, want 2", wait_cnt);
        end
        repeat (30) cycle(1'b1);
        repeat (20) cycle(1'b0);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            cycle(1'b1);
            found = if_p.O_vtg_sof;
        end
        n_cmp++;
        if (!found || (cyc - t0) != FRAME) begin
            n_bad++;
            $display("FAIL no_gap_sof: got found=%0b interval=%0d, want 1 and %0d", found, cyc - t0, FRAME);
        end
    endtask

    task automatic test_reset_mid();
        out_t a;
        bit   found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            cycle(1'b1);
            found = if_p.O_vtg_de && (if_p.O_vtg_y == 12'd1) && (if_p.O_vtg_x == 12'd4);
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL rst_wait_h5v1: got timeout, want (5,1) within 300 clks");
        end
        rst = 1'b1;
        #1;
        a = sample_p();
        n_cmp++;
        if (a !== INACT_P) begin
            n_bad++;
            $display("FAIL async_rst_pos: got %s, want %s", fmt(a), fmt(INACT_P));
        end
        a = sample_n();
        n_cmp++;
        if (a !== INACT_N) begin
            n_bad++;
            $display("FAIL async_rst_neg: got %s, want %s", fmt(a), fmt(INACT_N));
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b1);
        cycle(1'b1);
        n_cmp++;
        if ({if_p.O_vtg_de, if_p.O_vtg_sof, if_p.O_vtg_x, if_p.O_vtg_y} !== {1'b1, 1'b1, 12'd0, 12'd0}) begin
            n_bad++;
            $display("FAIL rst_restart: got de=%b sof=%b x=%0d y=%0d, want de=1 sof=1 x=0 y=0",
                     if_p.O_vtg_de, if_p.O_vtg_sof, if_p.O_vtg_x, if_p.O_vtg_y);
        end
    endtask

    task automatic test_polarity();
        int hs_low = 0, vs_low = 0, de_cnt = 0, sof_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            cycle(1'b1);
            hs_low  += int'(!if_n.O_vtg_hs);
            vs_low  += int'(!if_n.O_vtg_vs);
            de_cnt  += int'(if_n.O_vtg_de);
            sof_cnt += int'(if_n.O_vtg_sof);
        end
        n_cmp++;
        if (hs_low != 24) begin n_bad++; $display("FAIL neg_hs_low: got %0d, want 24", hs_low); end
        n_cmp++;
        if (vs_low != 32) begin n_bad++; $display("FAIL neg_vs_low: got %0d, want 32", vs_low); end
        n_cmp++;
        if (de_cnt != 32 || sof_cnt != 1) begin
            n_bad++;
            $display("FAIL neg_de_sof: got de=%0d sof=%0d, want 32 and 1", de_cnt, sof_cnt);
        end
    endtask

    initial begin
        if_p.I_vtg_en = 1'b0;
        if_n.I_vtg_en = 1'b0;
        test_reset();
        test_start();
        test_free_run();
        test_stop_mid();
        test_back_to_back();
        test_reset_mid();
        test_polarity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
